// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/STALL sequencer feeding a 2-entry {instr, pc} FIFO.
// Define FETCH_BRANCH_EN to enable taken-branch decode and the pc_control/jump_offset pulse.
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       out_valid,
    output logic [7:0] out_instr,
    output logic [7:0] out_pc,
    input  logic       out_ready,
    output logic       pc_control,
    output logic [7:0] jump_offset
);

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } entry_t;

    state_t           state;
    logic [7:0]       pc;
    entry_t [1:0]     q;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       cnt_nxt;
    logic             push;
    logic             pop;
    logic [7:0]       pc_step;

    // An ack only counts while a request is outstanding.
    assign push = (state == FETCH) && mem_ack;
    assign pop  = out_ready && (count != 2'd0);

    always_comb begin
        cnt_nxt = count + {1'b0, push} - {1'b0, pop};
    end

`ifdef FETCH_BRANCH_EN
    logic       is_br;
    logic [7:0] br_off;

    assign is_br   = (mem_rdata[7:6] == 2'b11);
    assign br_off  = {{2{mem_rdata[5]}}, mem_rdata[5:0]};
    assign pc_step = 8'd1 + (is_br ? br_off : 8'd0);

    // One-cycle pulse trailing the ack of a taken branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_control  <= 1'b0;
            jump_offset <= 8'h00;
        end else if (push && is_br) begin
            pc_control  <= 1'b1;
            jump_offset <= br_off;
        end else begin
            pc_control  <= 1'b0;
            jump_offset <= 8'h00;
        end
    end
`else
    assign pc_step     = 8'd1;
    assign pc_control  = 1'b0;
    assign jump_offset = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            mem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && count != 2'd2) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    // Request is held until acked, even if en drops.
                    if (mem_ack) begin
                        pc <= pc + pc_step;
                        if (cnt_nxt == 2'd2) begin
                            state   <= STALL;
                            mem_req <= 1'b0;
                        end else if (!en) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                STALL: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count != 2'd2) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q[wr_ptr] <= '{instr: mem_rdata, pc: pc};
                wr_ptr    <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= cnt_nxt;
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_instr = q[rd_ptr].instr;
    assign out_pc    = q[rd_ptr].pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch checked against a queue-based behavioural fetch model.
module tb_instr_fetch;

`ifdef FETCH_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       out_ready = 1'b0;
    logic       mem_req, out_valid, pc_control;
    logic [7:0] mem_addr, out_instr, out_pc, jump_offset;
    logic       mem_req2, out_valid2, pc_control2;
    logic [7:0] mem_addr2, out_instr2, out_pc2, jump_offset2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .pc_control(pc_control), .jump_offset(jump_offset)
    );

    instr_fetch #(.RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid2),
        .out_instr(out_instr2), .out_pc(out_pc2), .out_ready(out_ready),
        .pc_control(pc_control2), .jump_offset(jump_offset2)
    );

    // Reference model: "busy" = request outstanding, "full_wait" = waiting for room.
    localparam int M_IDLE = 0, M_BUSY = 1, M_WAIT = 2;
    int          m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_q[$];
    logic        m_pcc;
    logic [7:0]  m_joff;

    task automatic model_reset(input logic [7:0] rpc);
        m_mode = M_IDLE;
        m_pc   = rpc;
        m_q.delete();
        m_pcc  = 1'b0;
        m_joff = 8'h00;
    endtask

    task automatic model_update();
        int         pre;
        logic       took, br;
        logic [7:0] off;
        pre    = m_q.size();
        took   = (m_mode == M_BUSY) && mem_ack;
        m_pcc  = 1'b0;
        m_joff = 8'h00;
        if (out_ready && pre > 0) void'(m_q.pop_front());
        if (took) begin
            m_q.push_back({mem_rdata, m_pc});
            br  = BR && (mem_rdata[7:6] == 2'b11);
            off = {{2{mem_rdata[5]}}, mem_rdata[5:0]};
            m_pc = m_pc + 8'd1 + (br ? off : 8'd0);
            if (br) begin
                m_pcc  = 1'b1;
                m_joff = off;
            end
        end
        case (m_mode)
            M_IDLE: if (en && pre < 2) m_mode = M_BUSY;
            M_BUSY: if (took) m_mode = (m_q.size() == 2) ? M_WAIT : (en ? M_BUSY : M_IDLE);
            default: if (!en) m_mode = M_IDLE; else if (pre < 2) m_mode = M_BUSY;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    function automatic logic [34:0] exp_vec();
        logic       v;
        logic [15:0] h;
        v = m_q.size() > 0;
        h = v ? m_q[0] : 16'h0;
        return {m_mode == M_BUSY, m_pc, v, h, m_pcc, m_joff};
    endfunction

    // Don't-care fields masked by the model's expectations.
    function automatic logic [34:0] dut_vec();
        logic v;
        v = m_q.size() > 0;
        return {mem_req, mem_addr, out_valid, v ? out_instr : 8'h0, v ? out_pc : 8'h0,
                pc_control, jump_offset};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; mem_ack = 1'b0; out_ready = 1'b0; mem_rdata = 8'h00;
        model_reset(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_vec() !== exp_vec() || mem_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_sequential();
        do_reset();
        en = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h01; out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec() || pc_control !== 1'b0) begin
                fails++;
                $display("FAIL sequential cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        int pulses = 0;
        do_reset();
        en = 1'b1; mem_ack = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            mem_rdata = (m_pc == 8'h04) ? 8'hC3 : (m_pc == 8'h10) ? 8'hFE : 8'h01;
            tick();
            @(negedge clk);
            if (pc_control) pulses++;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL branch cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        tests++;
        if ((pulses != 0) !== BR) begin
            fails++;
            $display("FAIL branch_pulse: saw %0d pulses, expected pulses=%0d", pulses, BR);
        end
    endtask

    task automatic test_stall();
        int reqs = 0;
        do_reset();
        en = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h01; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
        end
        tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL stall_full: got %h expected %h", dut_vec(), exp_vec());
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req && mem_ack) reqs++;
            tick();
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL stall_pop cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (reqs !== 1) begin
            fails++;
            $display("FAIL stall_refill: got %0d requests, expected 1", reqs);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            en        = ($urandom_range(0, 9) < 8);
            mem_ack   = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            mem_rdata = 8'($urandom);
            tick();
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h01; out_ready = 1'b0;
        tick(); @(negedge clk);
        mem_ack = 1'b1;
        tick(); @(negedge clk);
        mem_ack = 1'b0;
        tick(); @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_setup: req %b valid %b, expected 1 1", mem_req, out_valid);
        end
        #2 rst = 1'b1;
        model_reset(8'h00);
        #1;
        tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || pc_control !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: req %b valid %b pcc %b, expected 0 0 0", mem_req, out_valid, pc_control);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; mem_ack = 1'b1;
        tick(); @(negedge clk);
        mem_ack = 1'b0;
        tests++;
        if (dut_vec() !== exp_vec() || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_late_ack: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_pc();
        do_reset();
        en = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h01; out_ready = 1'b1;
        tests++;
        if (mem_addr2 !== 8'hFF || mem_req2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_pc_init: addr %h req %b, expected ff 0", mem_addr2, mem_req2);
        end
        tick(); @(negedge clk);
        tests++;
        if (mem_addr2 !== 8'hFF || mem_req2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_pc_first: addr %h req %b, expected ff 1", mem_addr2, mem_req2);
        end
        tick(); @(negedge clk);
        tests++;
        if (mem_addr2 !== 8'h00 || out_pc2 !== 8'hFF) begin
            fails++;
            $display("FAIL reset_pc_wrap: addr %h out_pc %h, expected 00 ff", mem_addr2, out_pc2);
        end
    endtask

    initial begin
        model_reset(8'h00);
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_random();
        test_reset_mid();
        test_reset_pc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
